// File: rtl/fml_pkg.sv
// ---------------------------------------------------------------------------
// fml_pkg
// Shared constants and types for the FML block-RAM responder.
//   FML_DW / FML_SW : data width and byte-lane count of one burst beat
//   FML_BURST       : beats per burst
//   WR_LAT / RD_LAT : cycles from the early ack to the first write / read beat
//   fml_state_t     : responder FSM states
// ---------------------------------------------------------------------------
package fml_pkg;

  localparam int FML_DW    = 64;
  localparam int FML_SW    = 8;
  localparam int FML_BURST = 4;

  localparam int WR_LAT = 2;
  localparam int RD_LAT = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_LAT,
    S_WDATA,
    S_RDATA
  } fml_state_t;

endpackage

// File: rtl/fml_bram_slave_mem.sv
// ---------------------------------------------------------------------------
// fml_bram_slave_mem
// Single-port synchronous RAM, 2^AW words of FML_DW bits, byte-lane writes,
// one cycle of read latency. Contents are never reset.
// Ports:
//   i_clk   : clock
//   i_addr  : word address, shared by read and write
//   i_we    : write strobe, qualified per lane by i_sel
//   i_sel   : byte-lane enables
//   i_wdata : write data
//   i_re    : read enable; o_rdata updates the cycle after
//   o_rdata : registered read data
// ---------------------------------------------------------------------------
module fml_bram_slave_mem
  import fml_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              i_clk,
  input  logic [AW-1:0]     i_addr,
  input  logic              i_we,
  input  logic [FML_SW-1:0] i_sel,
  input  logic [FML_DW-1:0] i_wdata,
  input  logic              i_re,
  output logic [FML_DW-1:0] o_rdata
);

  logic [FML_DW-1:0] r_mem [0:(1<<AW)-1];
  logic [FML_DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < FML_SW; i++) begin
        if (i_sel[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fml_bram_slave.sv
// ---------------------------------------------------------------------------
// fml_bram_slave
// FML responder backed by block RAM. Accepts one 4-beat 64-bit burst at a
// time, pulses fml_eack once per accepted request and then follows the fixed
// post-ack timing the masters expect: write beats sampled at T+2..T+5, read
// beats driven at T+5+TIM_CAS..T+8+TIM_CAS (T = eack cycle).
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   fml_adr            : burst byte address (bits [DEPTH_LOG2+2:5] used)
//   fml_stb, fml_we    : request strobe and direction
//   fml_eack           : early ack pulse
//   fml_sel, fml_di    : write beat byte enables and data
//   fml_do             : read beat data, zero outside read beats
// ---------------------------------------------------------------------------
module fml_bram_slave
  import fml_pkg::*;
#(
  parameter int ADR_WIDTH  = 26,
  parameter int DEPTH_LOG2 = 10,
  parameter int TIM_CAS    = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [ADR_WIDTH-1:0] fml_adr,
  input  logic                 fml_stb,
  input  logic                 fml_we,
  output logic                 fml_eack,
  input  logic [FML_SW-1:0]    fml_sel,
  input  logic [FML_DW-1:0]    fml_di,
  output logic [FML_DW-1:0]    fml_do
);

  localparam int IDX_W = (DEPTH_LOG2 > 2) ? DEPTH_LOG2 - 2 : 1;

  // LAT lasts exactly "load" cycles. Writes need one cycle between ack and
  // the first beat. Reads spend their last LAT cycle plus one RDATA cycle on
  // issuing the first address and waiting out the RAM's read latency.
  localparam logic [2:0] WR_LOAD = 3'(WR_LAT - 1);
  localparam logic [2:0] RD_LOAD = 3'(RD_LAT - 2 + TIM_CAS);

  fml_state_t        r_state;
  logic              r_eack;
  logic              r_we;
  logic [IDX_W-1:0]  r_idx;
  logic [2:0]        r_cnt;
  logic [1:0]        r_beat;
  logic              r_rdv;

  logic [IDX_W-1:0]      w_idxIn;
  logic [DEPTH_LOG2-1:0] w_ramAddr;
  logic                  w_ramWe;
  logic                  w_ramRe;
  logic [FML_DW-1:0]     w_ramQ;
  logic                  w_unused;

  // Burst index lives above the 32-byte burst offset; higher bits alias.
  generate
    if (DEPTH_LOG2 > 2) begin : g_idx
      assign w_idxIn   = fml_adr[DEPTH_LOG2+2:5];
      assign w_ramAddr = {r_idx, r_beat};
    end else begin : g_noIdx
      assign w_idxIn   = '0;
      assign w_ramAddr = r_beat;
    end
  endgenerate

  assign w_unused = ^{fml_adr, r_idx};

  // In RDATA the beat counter is the read address, running one cycle ahead
  // of the data on fml_do. r_rdv marks cycles where the RAM output is a live
  // beat; the fifth RDATA cycle presents beat 3 with the counter wrapped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_eack  <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_rdv   <= 1'b0;
    end else begin
      r_eack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fml_stb) begin
            r_idx   <= w_idxIn;
            r_we    <= fml_we;
            r_eack  <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_cnt   <= r_we ? WR_LOAD : RD_LOAD;
          r_state <= S_LAT;
        end
        S_LAT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= r_we ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: begin
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            r_state <= S_IDLE;
          end
        end
        S_RDATA: begin
          r_rdv  <= 1'b1;
          r_beat <= r_beat + 2'd1;
          if (r_rdv && (r_beat == 2'd0)) begin
            r_rdv   <= 1'b0;
            r_beat  <= 2'd0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_ramWe = (r_state == S_WDATA);
  assign w_ramRe = (r_state == S_RDATA);

  fml_bram_slave_mem #(
    .AW (DEPTH_LOG2)
  ) u_mem (
    .i_clk   (sys_clk),
    .i_addr  (w_ramAddr),
    .i_we    (w_ramWe),
    .i_sel   (fml_sel),
    .i_wdata (fml_di),
    .i_re    (w_ramRe),
    .o_rdata (w_ramQ)
  );

  // RAM output has no reset, so gate it with the async-reset valid flag.
  assign fml_do   = r_rdv ? w_ramQ : '0;
  assign fml_eack = r_eack;

endmodule
